pipe_ctrl: RTL
==============

# pipe_ctrl

Pipeline hazard and control unit for the five-stage Y86 pipeline. It generates the stall and bubble signals consumed by the fetch, decode, execute, memory and write-back pipeline registers, including E_bubble for the execute register. It also sequences the pipeline through a post-reset flush and a sticky halt. Optional performance counters track stall and flush events.

## Interface
Parameters:
- CNT_W, 32, width of each performance counter.
- FLUSH_CYC, 3, number of post-reset flush cycles (1–7).

Ports:
- clk  in  1  pipeline clock; state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- D_icode  in  4  icode held in the decode register.
- d_srcA, d_srcB  in  4 each  decode-stage source registers (4'hF = none).
- E_icode  in  4  icode held in the execute register.
- E_dstM  in  4  execute-stage memory destination (4'hF = none).
- e_Cnd  in  1  execute-stage condition result.
- M_icode  in  4  icode held in the memory register.
- m_stat  in  3  memory-stage status.
- W_stat  in  3  write-back-stage status.
- F_stall, D_stall, W_stall  out  1 each  hold the corresponding register.
- D_bubble, E_bubble, M_bubble  out  1 each  inject a bubble into the corresponding register.
- halted  out  1  pipeline is in the HALTED state.
- cnt_loaduse, cnt_mispred, cnt_ret  out  CNT_W each  performance counters; present only with the macro defined.

## Operation
Encodings:
- Status: AOK=1, HLT=2, ADR=3, INS=4.
- icode: MRMOVQ=5, JXX=7, RET=9, POPQ=B.

Hazard terms (combinational):
- loaduse = E_icode∈{5,B} && E_dstM≠F && E_dstM∈{d_srcA,d_srcB}.
- mispred = E_icode==7 && !e_Cnd.
- ret = 9∈{D_icode,E_icode,M_icode}.
- exc_m = m_stat∈{2,3,4}.
- exc_w = W_stat∈{2,3,4}.

Control outputs in RUN:
- F_stall = loaduse | ret.
- D_stall = loaduse.
- D_bubble = mispred | (!loaduse & ret).
- E_bubble = mispred | loaduse.
- M_bubble = exc_m | exc_w.
- W_stall = exc_w.

States:
- FLUSH: entered on reset; lasts FLUSH_CYC cycles, counted by an internal down-counter.
  - Outputs: D_bubble=E_bubble=M_bubble=1; all stalls 0; halted=0.
  - Purpose: clears the pipeline registers, which have no reset.
  - Exits to RUN when the counter reaches 0.
- RUN: outputs as defined above.
  - exc_w=1 at a rising edge moves the state to HALTED.
- HALTED: sticky until rst_n is asserted.
  - Outputs: F_stall=D_stall=W_stall=1, M_bubble=1, E_bubble=0, D_bubble=0; halted=1.
  - Hazard inputs are ignored.

Simultaneous conditions:
- loaduse and ret together: loaduse wins. D_stall=1, D_bubble=0, E_bubble=1.
- mispred and loaduse together cannot both be real, since E holds a single icode. If both evaluate true, outputs follow the formulas unchanged: D_stall=1, D_bubble=1, E_bubble=1. The D register gives bubble priority over stall.

## Timing
- While rst_n=0 (asynchronous):
  - State=FLUSH, counter=FLUSH_CYC.
  - Counters cleared to 0.
  - Outputs: D_bubble=E_bubble=M_bubble=1, F_stall=D_stall=W_stall=0, halted=0.
- Reset is legal mid-operation, including from HALTED, and returns the block to FLUSH.
- Output latency: 0 cycles. Hazard outputs are combinational from inputs and the current state; only the state, flush counter and perf counters are registered.
- First RUN cycle is the (FLUSH_CYC+1)-th rising edge after rst_n deasserts.
- RUN→HALTED takes effect on the edge where exc_w=1. halted rises after that edge; outputs for the cycle of the exception still follow the RUN formulas.

## Configuration
Macro PIPE_PERF_CNT_EN:
- Defined: cnt_loaduse, cnt_mispred and cnt_ret each increment by 1 per RUN cycle in which loaduse, mispred or ret (respectively) is 1.
  - Counters saturate at 2^CNT_W−1.
  - Counters are frozen in FLUSH and HALTED.
- Undefined: the counter ports and registers are absent. Control behaviour is identical.

## Test plan
- Reset and flush: hold rst_n=0 for 2 cycles, then release. Required: D/E/M_bubble=1 for exactly 3 edges, then RUN with all outputs 0 for idle inputs (icodes=1, stat=1).
- Load-use: E_icode=5, E_dstM=3, d_srcA=3. Required: F_stall=D_stall=E_bubble=1, D_bubble=0. With E_dstM=F and d_srcB=F, all outputs are 0.
- Mispredict: E_icode=7, e_Cnd=0. Required: D_bubble=E_bubble=1, F_stall=0. With e_Cnd=1, all outputs are 0.
- Return: RET walks D→E→M over 3 cycles. Required: F_stall=1 and D_bubble=1 each cycle. With PIPE_PERF_CNT_EN defined, cnt_ret=3.
- Exception halt: m_stat=3 for 1 cycle, then W_stat=3. Required: M_bubble=1 in both cycles; halted=1 after the W edge; stays HALTED with all inputs returned to AOK until rst_n=0.
- Combined hazard: loaduse together with D_icode=9. Required: D_stall=1, D_bubble=0, E_bubble=1. Saturation: with CNT_W=4, 20 load-use cycles give cnt_loaduse=15.

Source files
------------

// File: rtl/pipe_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_ctrl
// Brief    : Y86 five-stage hazard/control unit with post-reset flush and
//            sticky halt. Optional perf counters via PIPE_PERF_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_ctrl #(
    parameter int CNT_W     = 32,
    parameter int FLUSH_CYC = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] D_icode,
    input  logic [3:0] d_srcA,
    input  logic [3:0] d_srcB,
    input  logic [3:0] E_icode,
    input  logic [3:0] E_dstM,
    input  logic       e_Cnd,
    input  logic [3:0] M_icode,
    input  logic [2:0] m_stat,
    input  logic [2:0] W_stat,
    output logic       F_stall,
    output logic       D_stall,
    output logic       W_stall,
    output logic       D_bubble,
    output logic       E_bubble,
    output logic       M_bubble,
    output logic       halted
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] cnt_loaduse,
    output logic [CNT_W-1:0] cnt_mispred,
    output logic [CNT_W-1:0] cnt_ret
`endif
);

    localparam logic [1:0] c_ST_FLUSH  = 2'd0;
    localparam logic [1:0] c_ST_RUN    = 2'd1;
    localparam logic [1:0] c_ST_HALTED = 2'd2;

    localparam logic [2:0] c_FLUSH_INIT = 3'(FLUSH_CYC);

    localparam logic [3:0] c_I_MRMOVQ = 4'h5;
    localparam logic [3:0] c_I_JXX    = 4'h7;
    localparam logic [3:0] c_I_RET    = 4'h9;
    localparam logic [3:0] c_I_POPQ   = 4'hB;
    localparam logic [3:0] c_R_NONE   = 4'hF;

    localparam logic [2:0] c_S_HLT = 3'd2;
    localparam logic [2:0] c_S_ADR = 3'd3;
    localparam logic [2:0] c_S_INS = 3'd4;

    logic [1:0] r_state;
    logic [1:0] w_state_nxt;
    logic [2:0] r_flush_cnt;
    logic [2:0] w_flush_cnt_nxt;

    logic w_loaduse;
    logic w_mispred;
    logic w_ret;
    logic w_exc_m;
    logic w_exc_w;

    assign w_loaduse = ((E_icode == c_I_MRMOVQ) || (E_icode == c_I_POPQ)) &&
                       (E_dstM != c_R_NONE) &&
                       ((E_dstM == d_srcA) || (E_dstM == d_srcB));
    assign w_mispred = (E_icode == c_I_JXX) && !e_Cnd;
    assign w_ret     = (D_icode == c_I_RET) || (E_icode == c_I_RET) ||
                       (M_icode == c_I_RET);
    assign w_exc_m   = (m_stat == c_S_HLT) || (m_stat == c_S_ADR) ||
                       (m_stat == c_S_INS);
    assign w_exc_w   = (W_stat == c_S_HLT) || (W_stat == c_S_ADR) ||
                       (W_stat == c_S_INS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= c_ST_FLUSH;
            r_flush_cnt <= c_FLUSH_INIT;
        end else begin
            r_state     <= w_state_nxt;
            r_flush_cnt <= w_flush_cnt_nxt;
        end
    end

    // Leaving FLUSH on the edge where the counter steps 1->0 gives exactly
    // FLUSH_CYC bubble cycles after reset release.
    always_comb begin
        w_state_nxt     = r_state;
        w_flush_cnt_nxt = r_flush_cnt;
        case (r_state)
            c_ST_FLUSH: begin
                if (r_flush_cnt != 3'd0) begin
                    w_flush_cnt_nxt = r_flush_cnt - 3'd1;
                end
                if (r_flush_cnt <= 3'd1) begin
                    w_state_nxt = c_ST_RUN;
                end
            end
            c_ST_RUN: begin
                if (w_exc_w) begin
                    w_state_nxt = c_ST_HALTED;
                end
            end
            c_ST_HALTED: begin
                w_state_nxt = c_ST_HALTED;
            end
            default: begin
                w_state_nxt = c_ST_FLUSH;
            end
        endcase
    end

    always_comb begin
        F_stall  = 1'b0;
        D_stall  = 1'b0;
        W_stall  = 1'b0;
        D_bubble = 1'b1;
        E_bubble = 1'b1;
        M_bubble = 1'b1;
        halted   = 1'b0;
        case (r_state)
            c_ST_RUN: begin
                F_stall  = w_loaduse | w_ret;
                D_stall  = w_loaduse;
                D_bubble = w_mispred | (!w_loaduse & w_ret);
                E_bubble = w_mispred | w_loaduse;
                M_bubble = w_exc_m | w_exc_w;
                W_stall  = w_exc_w;
            end
            c_ST_HALTED: begin
                F_stall  = 1'b1;
                D_stall  = 1'b1;
                W_stall  = 1'b1;
                D_bubble = 1'b0;
                E_bubble = 1'b0;
                M_bubble = 1'b1;
                halted   = 1'b1;
            end
            default: begin
                F_stall = 1'b0;
            end
        endcase
    end

`ifdef PIPE_PERF_CNT_EN
    logic w_run;
    assign w_run = (r_state == c_ST_RUN);

    // Saturating event counters, only advancing while the pipeline runs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_loaduse <= '0;
            cnt_mispred <= '0;
            cnt_ret     <= '0;
        end else if (w_run) begin
            if (w_loaduse && !(&cnt_loaduse)) cnt_loaduse <= cnt_loaduse + 1'b1;
            if (w_mispred && !(&cnt_mispred)) cnt_mispred <= cnt_mispred + 1'b1;
            if (w_ret && !(&cnt_ret))         cnt_ret     <= cnt_ret + 1'b1;
        end
    end
`endif

endmodule
`default_nettype wire
